// File: rtl/proc_pkg.sv
// Shared definitions for the image-convolution processor front end:
// field widths, opcode constants and the fetch FSM state encoding.
package proc_pkg;

  localparam int PC_W    = 8;
  localparam int OPC_W   = 6;
  localparam int INSTR_W = OPC_W + PC_W;

  // Instruction word is {opcode, operand}, opcode in the MSBs.
  localparam int OPC_MSB = INSTR_W - 1;
  localparam int OPC_LSB = PC_W;
  localparam int OPD_MSB = PC_W - 1;
  localparam int OPD_LSB = 0;

  localparam logic [OPC_W-1:0] HALT_OPC = 6'd63;
  localparam logic [OPC_W-1:0] FETCH2   = 6'd1;
  localparam logic [OPC_W-1:0] JUMPZ    = 6'd52;
  localparam logic [OPC_W-1:0] JUMPNZ   = 6'd48;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [PC_W-1:0] instr_operand(input logic [INSTR_W-1:0] word);
    return word[OPD_MSB:OPD_LSB];
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter with jump load and wrapping increment; load wins over
// increment when both are requested.
module pc_register
  import proc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load_en,
  input  logic [PC_W-1:0] load_addr,
  input  logic            inc_en,
  output logic [PC_W-1:0] pc
);

  // PC update: reset, jump load, then increment (modulo 2^PC_W by truncation)
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= {PC_W{1'b0}};
    end else if (load_en) begin
      pc <= load_addr;
    end else if (inc_en) begin
      pc <= pc + {{(PC_W-1){1'b0}}, 1'b1};
    end else begin
      pc <= pc;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: drives instruction memory from the PC, captures the
// returned word into the instruction register and stops on HALT.
module instr_fetch_unit
  import proc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               fetch_req,
  input  logic               jump_en,
  input  logic [PC_W-1:0]    jump_addr,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_rvalid,
  output logic [OPC_W-1:0]   mbru,
  output logic [PC_W-1:0]    operand,
  output logic               instr_valid,
  output logic               halted
);

  fetch_state_e     state_r;
  logic [PC_W-1:0]  pc_r;
  logic             load_en_s;
  logic             inc_en_s;
  logic [OPC_W-1:0] rd_opc_s;
  logic [PC_W-1:0]  rd_opd_s;

  // Jumps only land in HOLD; the PC advances on the captured read only
  always_comb begin
    load_en_s = 1'b0;
    inc_en_s  = 1'b0;
    rd_opc_s  = instr_opcode(imem_rdata);
    rd_opd_s  = instr_operand(imem_rdata);
    if (state_r == ST_HOLD) begin
      load_en_s = jump_en;
    end else begin
      load_en_s = 1'b0;
    end
    if (state_r == ST_FETCH) begin
      inc_en_s = imem_rvalid;
    end else begin
      inc_en_s = 1'b0;
    end
  end

  pc_register u_pc_register (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en_s),
    .load_addr (jump_addr),
    .inc_en    (inc_en_s),
    .pc        (pc_r)
  );

  // The address is the registered PC, so it is stable through a FETCH
  assign imem_addr = pc_r;

  // Fetch sequencing FSM with registered request and instruction register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      imem_req    <= 1'b0;
      mbru        <= {OPC_W{1'b0}};
      operand     <= {PC_W{1'b0}};
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable) begin
            state_r  <= ST_FETCH;
            imem_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (imem_rvalid) begin
            mbru        <= rd_opc_s;
            operand     <= rd_opd_s;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            if (rd_opc_s == HALT_OPC) begin
              state_r <= ST_HALTED;
              halted  <= 1'b1;
            end else begin
              state_r <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // Without enable a fetch request is dropped and the unit stalls here
          if (fetch_req && enable) begin
            state_r     <= ST_FETCH;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        ST_HALTED: begin
          state_r <= ST_HALTED;
        end
        default: begin
          state_r  <= ST_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit against a
// transaction-level model of the PC and instruction register.
module tb_instr_fetch_unit;
  import proc_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               fetch_req;
  logic               jump_en;
  logic [PC_W-1:0]    jump_addr;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_rvalid;
  logic [OPC_W-1:0]   mbru;
  logic [PC_W-1:0]    operand;
  logic               instr_valid;
  logic               halted;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .fetch_req   (fetch_req),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .mbru        (mbru),
    .operand     (operand),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [INSTR_W-1:0] mem [256];

  // Reference state: what the program-visible registers should hold
  logic [7:0] m_pc;
  logic [5:0] m_mbru;
  logic [7:0] m_oper;
  logic       m_valid;
  logic       m_halted;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_mbru = 6'd0; m_oper = 8'h00; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  task automatic check_model(input string where);
    check_eq({where, ".mbru"},        32'(mbru),        32'(m_mbru));
    check_eq({where, ".operand"},     32'(operand),     32'(m_oper));
    check_eq({where, ".instr_valid"}, 32'(instr_valid), 32'(m_valid));
    check_eq({where, ".halted"},      32'(halted),      32'(m_halted));
    check_eq({where, ".imem_req"},    32'(imem_req),    32'(1'b0));
    check_eq({where, ".imem_addr"},   32'(imem_addr),   32'(m_pc));
  endtask

  // One complete fetch: request, wait lat cycles, return mem[addr], compare.
  task automatic fetch_txn(input int lat, input logic use_jump, input logic [7:0] jaddr,
                           input logic from_idle);
    logic [7:0]  a;
    logic [13:0] w;
    enable = 1'b1;
    if (!from_idle) begin
      fetch_req = 1'b1;
      jump_en   = use_jump;
      jump_addr = jaddr;
    end
    step();
    a = use_jump ? jaddr : m_pc;
    check_eq("fetch.valid_drop", 32'(instr_valid), 32'(1'b0));
    for (int c = 0; c <= lat; c++) begin
      check_eq("fetch.imem_req",  32'(imem_req),  32'(1'b1));
      check_eq("fetch.imem_addr", 32'(imem_addr), 32'(a));
      // Inputs that must be ignored while fetching
      enable      = 1'($urandom_range(0, 1));
      fetch_req   = 1'($urandom_range(0, 1));
      jump_en     = 1'($urandom_range(0, 1));
      jump_addr   = 8'($urandom);
      imem_rvalid = (c == lat);
      imem_rdata  = (c == lat) ? mem[a] : 14'($urandom);
      step();
    end
    imem_rvalid = 1'b0;
    fetch_req   = 1'b0;
    jump_en     = 1'b0;
    w        = mem[a];
    m_pc     = a + 8'd1;
    m_mbru   = w[13:8];
    m_oper   = w[7:0];
    m_valid  = 1'b1;
    m_halted = (w[13:8] == 6'd63);
    check_model("fetch");
  endtask

  // Idle cycles in HOLD: stalled fetch requests and stand-alone jumps
  task automatic hold_stall(input int n);
    logic [7:0] ja;
    for (int i = 0; i < n; i++) begin
      ja        = 8'($urandom);
      jump_en   = 1'($urandom_range(0, 1));
      jump_addr = ja;
      fetch_req = 1'($urandom_range(0, 1));
      enable    = fetch_req ? 1'b0 : 1'($urandom_range(0, 1));
      step();
      if (jump_en) m_pc = ja;
      check_model("hold");
    end
    jump_en   = 1'b0;
    fetch_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = {6'($urandom_range(0, 62)), 8'($urandom)};
    end
    mem[0]     = {6'd4, 8'h10};
    mem[8'hC3] = {6'd63, 8'h5A};

    reset = 1'b1; enable = 1'b0; fetch_req = 1'b0; jump_en = 1'b0;
    jump_addr = 8'h00; imem_rdata = 14'h0; imem_rvalid = 1'b0;
    model_reset();
    repeat (3) step();
    check_model("reset");
    reset = 1'b0;
    step();
    check_model("idle");

    // First fetch from address 0 with two-cycle latency
    fetch_txn(2, 1'b0, 8'h00, 1'b1);
    check_eq("first.mbru",    32'(mbru),      32'(6'd4));
    check_eq("first.operand", 32'(operand),   32'(8'h10));
    check_eq("first.pc",      32'(imem_addr), 32'(8'h01));

    hold_stall(3);
    // Jump and fetch in the same cycle: fetch uses the jump target
    fetch_txn(int'($urandom_range(0, 3)), 1'b1, 8'h2F, 1'b0);
    check_eq("jumpfetch.pc", 32'(imem_addr), 32'(8'h30));

    // Wrap: jump to 0xFF, fetch, next fetch from 0x00
    jump_en = 1'b1; jump_addr = 8'hFF;
    step();
    jump_en = 1'b0; m_pc = 8'hFF;
    check_model("jump_ff");
    fetch_txn(1, 1'b0, 8'h00, 1'b0);
    check_eq("wrap.pc", 32'(imem_addr), 32'(8'h00));
    fetch_txn(0, 1'b0, 8'h00, 1'b0);

    for (int t = 0; t < 40; t++) begin
      hold_stall(int'($urandom_range(0, 3)));
      fetch_txn(int'($urandom_range(0, 4)), 1'($urandom_range(0, 3) == 0),
                8'($urandom_range(0, 8'hC2)), 1'b0);
    end

    // HALT: everything afterwards is ignored
    fetch_txn(1, 1'b1, 8'hC3, 1'b0);
    check_eq("halt.halted", 32'(halted), 32'(1'b1));
    check_eq("halt.mbru",   32'(mbru),   32'(6'd63));
    for (int i = 0; i < 6; i++) begin
      enable      = 1'b1;
      fetch_req   = 1'b1;
      jump_en     = 1'($urandom_range(0, 1));
      jump_addr   = 8'($urandom);
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = {6'd5, 8'($urandom)};
      step();
      check_model("halted");
    end

    // Reset during the second FETCH cycle, then a stale rvalid
    enable = 1'b0; fetch_req = 1'b0; jump_en = 1'b0; imem_rvalid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    step();
    check_model("rst2");
    enable = 1'b1;
    step();
    enable = 1'b0;
    check_eq("abort.req1", 32'(imem_req), 32'(1'b1));
    step();
    check_eq("abort.req2", 32'(imem_req), 32'(1'b1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_model("abort.after_reset");
    imem_rvalid = 1'b1;
    imem_rdata  = {6'd9, 8'h77};
    step();
    imem_rvalid = 1'b0;
    check_model("abort.late_rvalid");
    step();
    check_model("abort.settled");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
